// File: rtl/text_vmem_if.sv
// Keyboard-to-video-memory key handshake: one ASCII code per cycle with p_valid/p_ready.
interface text_vmem_if;
  logic [7:0] key_in;
  logic       p_valid;
  logic       p_ready;

  modport master (output key_in, output p_valid, input p_ready);
  modport slave  (input key_in, input p_valid, output p_ready);
endinterface

// File: rtl/text_vmem.sv
// Text-mode video memory with write cursor, newline/backspace and registered VGA read port.
// Optional hardware scrolling through a circular row offset: define VMEM_SCROLL_EN.
module text_vmem #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 9,
  parameter int CHAR_H = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  text_vmem_if.slave                kb,
  input  logic [$clog2(COLS)-1:0]   x,
  input  logic [$clog2(ROWS)-1:0]   y,
  input  logic [9:0]                h_addr,
  input  logic [9:0]                v_addr,
  output logic [7:0]                ascii_out,
  output logic [$clog2(CHAR_H)-1:0] row,
  output logic [$clog2(CHAR_W)-1:0] col,
  output logic [$clog2(COLS)-1:0]   cur_x,
  output logic [$clog2(ROWS)-1:0]   cur_y
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int GW = $clog2(CHAR_W);
  localparam int GH = $clog2(CHAR_H);
  localparam int AW = XW + YW;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [YW:0]   ROWS_W = (YW + 1)'(ROWS);

`ifdef VMEM_SCROLL_EN
  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_CLEAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1} state_t;
`endif

  state_t        state_r;
  logic [XW-1:0] cnt_x_r;
  logic [YW-1:0] cnt_y_r;
  logic [YW-1:0] top_r;
  logic          p_ready_r;
`ifdef VMEM_SCROLL_EN
  logic [YW-1:0] clr_row_r;
`endif
  logic [7:0]    mem_r [0:(1 << AW) - 1];

  logic          accept_s;
  logic [XW-1:0] nxt_x_s;
  logic [YW-1:0] nxt_y_s;
  logic          key_we_s;
  logic [XW-1:0] key_wx_s;
  logic [YW-1:0] key_wy_s;
  logic [7:0]    key_wd_s;
  logic          ovf_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [7:0]    wdata_s;

  // (ry + rt) mod ROWS without a divider; both operands are below ROWS
  function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] ry, input logic [YW-1:0] rt);
    logic [YW:0] sum;
    sum = {1'b0, ry} + {1'b0, rt};
    if (sum >= ROWS_W) begin
      sum = sum - ROWS_W;
    end else begin
      sum = sum;
    end
    return sum[YW-1:0];
  endfunction

  assign kb.p_ready = p_ready_r;
  assign accept_s   = kb.p_valid && p_ready_r;

  // Decode the offered key into the next cursor position and an optional cell write
  always_comb begin
    nxt_x_s  = cur_x;
    nxt_y_s  = cur_y;
    key_we_s = 1'b0;
    key_wx_s = cur_x;
    key_wy_s = cur_y;
    key_wd_s = kb.key_in;
    ovf_s    = 1'b0;
    if (kb.key_in >= 8'h20 && kb.key_in <= 8'h7E) begin
      key_we_s = 1'b1;
      if (cur_x == X_LAST) begin
        nxt_x_s = {XW{1'b0}};
        if (cur_y == Y_LAST) ovf_s = 1'b1;
        else                 nxt_y_s = cur_y + YW'(1);
      end else begin
        nxt_x_s = cur_x + XW'(1);
      end
    end else if (kb.key_in == 8'h0A) begin
      nxt_x_s = {XW{1'b0}};
      if (cur_y == Y_LAST) ovf_s = 1'b1;
      else                 nxt_y_s = cur_y + YW'(1);
    end else if (kb.key_in == 8'h08) begin
      key_wd_s = 8'h00;
      if (cur_x != {XW{1'b0}}) begin
        nxt_x_s  = cur_x - XW'(1);
        key_we_s = 1'b1;
        key_wx_s = cur_x - XW'(1);
      end else if (cur_y != {YW{1'b0}}) begin
        nxt_x_s  = X_LAST;
        nxt_y_s  = cur_y - YW'(1);
        key_we_s = 1'b1;
        key_wx_s = X_LAST;
        key_wy_s = cur_y - YW'(1);
      end else begin
        key_we_s = 1'b0;
      end
    end else begin
      key_we_s = 1'b0;
    end
    // Overflow past the bottom row: stay on the last row when scrolling, otherwise wrap home
    if (ovf_s) begin
`ifdef VMEM_SCROLL_EN
      nxt_y_s = Y_LAST;
`else
      nxt_y_s = {YW{1'b0}};
`endif
    end else begin
      nxt_y_s = nxt_y_s;
    end
  end

  // Select the single memory write source for this cycle
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {AW{1'b0}};
    wdata_s = 8'h00;
    case (state_r)
      ST_INIT: begin
        we_s    = 1'b1;
        waddr_s = {cnt_y_r, cnt_x_r};
      end
      ST_IDLE: begin
        we_s    = accept_s && key_we_s;
        waddr_s = {phys_row(key_wy_s, top_r), key_wx_s};
        wdata_s = key_wd_s;
      end
`ifdef VMEM_SCROLL_EN
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = {clr_row_r, cnt_x_r};
      end
`endif
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Control FSM: init sweep, key acceptance and cursor, scroll-clear sweep
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_INIT;
      cnt_x_r   <= {XW{1'b0}};
      cnt_y_r   <= {YW{1'b0}};
      top_r     <= {YW{1'b0}};
      cur_x     <= {XW{1'b0}};
      cur_y     <= {YW{1'b0}};
      p_ready_r <= 1'b0;
`ifdef VMEM_SCROLL_EN
      clr_row_r <= {YW{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_INIT: begin
          if (cnt_x_r == X_LAST) begin
            cnt_x_r <= {XW{1'b0}};
            if (cnt_y_r == Y_LAST) begin
              cnt_y_r   <= {YW{1'b0}};
              state_r   <= ST_IDLE;
              p_ready_r <= 1'b1;
            end else begin
              cnt_y_r <= cnt_y_r + YW'(1);
            end
          end else begin
            cnt_x_r <= cnt_x_r + XW'(1);
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            cur_x <= nxt_x_s;
            cur_y <= nxt_y_s;
`ifdef VMEM_SCROLL_EN
            // The old top physical row becomes the new bottom and must be blanked
            if (ovf_s) begin
              top_r     <= phys_row(YW'(1), top_r);
              clr_row_r <= top_r;
              cnt_x_r   <= {XW{1'b0}};
              p_ready_r <= 1'b0;
              state_r   <= ST_CLEAR;
            end
`endif
          end
        end
`ifdef VMEM_SCROLL_EN
        ST_CLEAR: begin
          if (cnt_x_r == X_LAST) begin
            cnt_x_r   <= {XW{1'b0}};
            p_ready_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            cnt_x_r <= cnt_x_r + XW'(1);
          end
        end
`endif
        default: begin
          state_r   <= ST_INIT;
          p_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Character storage; read port below sees pre-write data in the same cycle
  always_ff @(posedge clk) begin
    if (we_s) mem_r[waddr_s] <= wdata_s;
  end

  // Registered read port: character under the beam plus glyph pixel offsets
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ascii_out <= 8'h00;
      row       <= {GH{1'b0}};
      col       <= {GW{1'b0}};
    end else begin
      ascii_out <= (state_r == ST_INIT) ? 8'h00 : mem_r[{phys_row(y, top_r), x}];
      row       <= GH'(v_addr - 10'(y) * 10'(CHAR_H));
      col       <= GW'(h_addr - 10'(x) * 10'(CHAR_W));
    end
  end
endmodule

// File: tb/tb_text_vmem.sv
// Randomized scoreboard bench for text_vmem against a screen-level reference model.
module tb_text_vmem;
  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] x = '0;
  logic [4:0] y = '0;
  logic [9:0] h_addr = '0;
  logic [9:0] v_addr = '0;
  logic [7:0] ascii_out;
  logic [3:0] row, col;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  text_vmem_if kb();

  text_vmem dut (
    .clk(clk), .reset(reset), .kb(kb),
    .x(x), .y(y), .h_addr(h_addr), .v_addr(v_addr),
    .ascii_out(ascii_out), .row(row), .col(col),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the visible screen as rows of characters, plus the cursor
  logic [7:0] scr [ROWS][COLS];
  int mx, my;

  typedef struct { int due; int qx; int qy; logic [7:0] a; logic [3:0] r; logic [3:0] c; } rd_t;
  typedef struct { int ex; int ey; } cur_t;
  rd_t  rq[$];
  cur_t cq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare read results and cursor updates as the DUT presents them
  always @(negedge clk) begin : mon
    rd_t  e;
    cur_t c;
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      e = rq.pop_front();
      chk("rd_due", cyc, e.due);
      chk($sformatf("ascii(%0d,%0d)", e.qx, e.qy), ascii_out, e.a);
      chk("row", row, e.r);
      chk("col", col, e.c);
    end
    while (cq.size() > 0) begin
      c = cq.pop_front();
      chk("cur_x", cur_x, c.ex);
      chk("cur_y", cur_y, c.ey);
    end
  end

  function automatic bit model_key(input logic [7:0] k);
    bit ov = 1'b0;
    if (k >= 8'h20 && k <= 8'h7E) begin
      scr[my][mx] = k;
      mx++;
      if (mx == COLS) begin mx = 0; my++; end
    end else if (k == 8'h0A) begin
      mx = 0; my++;
    end else if (k == 8'h08) begin
      if (mx > 0) begin mx--; scr[my][mx] = 8'h00; end
      else if (my > 0) begin my--; mx = COLS - 1; scr[my][mx] = 8'h00; end
    end
    if (my == ROWS) begin
`ifdef VMEM_SCROLL_EN
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
      my = ROWS - 1;
      ov = 1'b1;
`else
      my = 0;
`endif
    end
    return ov;
  endfunction

  // All driver tasks start and end at #1 after a rising edge
  task automatic do_reset();
    int n;
    repeat (2) @(posedge clk);
    #1;
    kb.p_valid = 1'b0;
    kb.key_in  = 8'h00;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p_ready", kb.p_ready, 0);
    chk("rst_cur_x", cur_x, 0);
    chk("rst_cur_y", cur_y, 0);
    chk("rst_ascii", ascii_out, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    rq.delete();
    cq.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    mx = 0;
    my = 0;
    reset = 1'b1;
    n = 0;
    while (kb.p_ready !== 1'b1 && n < 3000) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("init_len", n, COLS * ROWS);
  endtask

  task automatic rd(input int qx, input int qy);
    rd_t e;
    int hv, vv;
    hv = $urandom_range(0, 1023);
    vv = $urandom_range(0, 1023);
    x = 7'(qx);
    y = 5'(qy);
    h_addr = 10'(hv);
    v_addr = 10'(vv);
    e.due = cyc + 1;
    e.qx = qx;
    e.qy = qy;
    e.a = scr[qy][qx];
    e.r = 4'((vv - qy * 16) & 15);
    e.c = 4'((hv - qx * 9) & 15);
    rq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] k, input int exp_wait);
    int w, n;
    bit sc;
    kb.key_in  = k;
    kb.p_valid = 1'b1;
    w = 0;
    while (kb.p_ready !== 1'b1 && w < 500) begin
      w++;
      @(posedge clk);
      #1;
    end
    if (w >= 500) begin
      chk("accept_timeout", w, 0);
      kb.p_valid = 1'b0;
      return;
    end
    if (exp_wait >= 0) chk("accept_wait", w, exp_wait);
    sc = model_key(k);
    @(posedge clk);
    #1;
    kb.p_valid = 1'b0;
    cq.push_back('{mx, my});
    n = 0;
    while (kb.p_ready !== 1'b1 && n < 500) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("ready_drop", n, sc ? COLS : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    do_reset();
    rd(5, 7);
    rd(COLS - 1, ROWS - 1);
    send(8'h41, 0);
    send(8'h42, 0);
    rd(0, 0);
    rd(1, 0);
    rd(2, 0);

    do_reset();
    send(8'h51, 0);
    send(8'h0A, 0);
    send(8'h08, 0);
    rd(COLS - 1, 0);
    rd(0, 0);

    do_reset();
    send(8'h08, 0);
    send(8'h1B, 0);
    rd(0, 0);
    rd(1, 0);

    // Thirty ENTERs in total, the last one running off the bottom row
    do_reset();
    send(8'h5A, 0);
    send(8'h0A, 0);
    send(8'h57, 0);
    send(8'h56, 0);
    for (int i = 0; i < 29; i++) send(8'h0A, 0);
    for (int c = 0; c < 3; c++) rd(c, 0);
    for (int c = 0; c < COLS; c++) rd(c, ROWS - 1);

    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      if (r < 75)      send(8'($urandom_range(32, 126)), 0);
      else if (r < 86) send(8'h0A, 0);
      else if (r < 95) send(8'h08, 0);
      else             send(8'($urandom_range(0, 255)), 0);
      if ($urandom_range(0, 3) == 0) rd($urandom_range(0, COLS - 1), $urandom_range(0, ROWS - 1));
      if ($urandom_range(0, 3) == 0) rd(mx, my);
    end

    for (int yy = 0; yy < ROWS; yy++)
      for (int xx = 0; xx < COLS; xx++) rd(xx, yy);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain", rq.size() + cq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
